// File: rtl/xbar_seq_if.sv
// Command/handshake and datapath-control bundle between the two requesters and xbar_seq.
interface xbar_seq_if;
  logic       req_a;
  logic       req_b;
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] dst_a;
  logic [1:0] dst_b;
  logic       ack_a;
  logic       ack_b;
  logic       busy;
  logic       done;
  logic [2:0] bus_sel;
  logic       data_sel;
  logic [3:0] rin;
  logic       scr_in;

  modport master (
    output req_a, req_b, op_a, op_b, src_a, src_b, dst_a, dst_b,
    input  ack_a, ack_b, busy, done, bus_sel, data_sel, rin, scr_in
  );

  modport slave (
    input  req_a, req_b, op_a, op_b, src_a, src_b, dst_a, dst_b,
    output ack_a, ack_b, busy, done, bus_sel, data_sel, rin, scr_in
  );
endinterface

// File: rtl/xbar_seq.sv
// Two-port command sequencer/arbiter for the four-register crossbar; SWAP runs
// as src->scratch, dst->src, scratch->dst over three cycles.
module xbar_seq #(
  parameter bit RR = 1'b1
) (
  input logic       clk,
  input logic       rst,
  xbar_seq_if.slave xif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SWAP2 = 2'd2;
  localparam logic [1:0] SWAP3 = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_SWAP = 2'd2;

  logic [1:0] state;
  logic [1:0] op_q;
  logic [1:0] src_q;
  logic [1:0] dst_q;
  logic       gport;
  logic       last_b;
  logic       grant_a;
  logic       grant_b;

  // On a tie A wins under fixed priority, or under round-robin when B was granted last.
  always_comb begin
    grant_a = (state == IDLE) && !rst && xif.req_a && (!xif.req_b || !RR || last_b);
    grant_b = (state == IDLE) && !rst && xif.req_b && !grant_a;
  end

  assign xif.ack_a = grant_a;
  assign xif.ack_b = grant_b;
  assign xif.busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      gport  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            op_q   <= grant_b ? xif.op_b  : xif.op_a;
            src_q  <= grant_b ? xif.src_b : xif.src_a;
            dst_q  <= grant_b ? xif.dst_b : xif.dst_a;
            gport  <= grant_b;
            last_b <= grant_b;
            state  <= EXEC;
          end
        end
        EXEC:    state <= (op_q == OP_SWAP && src_q != dst_q) ? SWAP2 : IDLE;
        SWAP2:   state <= SWAP3;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    xif.bus_sel  = '0;
    xif.data_sel = 1'b0;
    xif.rin      = '0;
    xif.scr_in   = 1'b0;
    xif.done     = 1'b0;
    case (state)
      EXEC: begin
        case (op_q)
          OP_LOAD: begin
            xif.data_sel = gport;
            xif.rin      = 4'b0001 << dst_q;
            xif.done     = 1'b1;
          end
          OP_COPY: begin
            xif.bus_sel = {1'b0, src_q} + 3'd1;
            xif.rin     = 4'b0001 << dst_q;
            xif.done    = 1'b1;
          end
          OP_SWAP: begin
            if (src_q != dst_q) begin
              xif.bus_sel = {1'b0, src_q} + 3'd1;
              xif.scr_in  = 1'b1;
            end else begin
              xif.done = 1'b1;
            end
          end
          default: xif.done = 1'b1;
        endcase
      end
      SWAP2: begin
        xif.bus_sel = {1'b0, dst_q} + 3'd1;
        xif.rin     = 4'b0001 << src_q;
      end
      SWAP3: begin
        xif.bus_sel = 3'd5;
        xif.rin     = 4'b0001 << dst_q;
        xif.done    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
